// File: rtl/dmem_access_unit_pkg.sv
// Shared types for the data-memory access unit: size codes, LSU FSM states
// and the write-buffer entry layout (sized for the widest data path).
package dmem_access_unit_pkg;

  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;
  localparam logic [1:0] MEM_SIZE_D = 2'b11;

  localparam int MAX_DATA_W = 64;
  localparam int MAX_STRB_W = MAX_DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_WAIT = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_WAIT = 3'd4,
    S_RD_DONE = 3'd5
  } lsu_state_t;

  // A 32-bit data path leaves the upper strobe/data bits of an entry at zero.
  typedef struct packed {
    logic [31:0]           addr;
    logic [1:0]            size;
    logic [MAX_STRB_W-1:0] wstrb;
    logic [MAX_DATA_W-1:0] wdata;
  } wbuf_entry_t;

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      MEM_SIZE_B: return 8'h01;
      MEM_SIZE_H: return 8'h03;
      MEM_SIZE_W: return 8'h0F;
      default:    return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/dmem_access_unit_wbuf.sv
// Posted-store FIFO. Push is ignored when full and pop when empty; a pop
// never frees a slot for a push in the same cycle.
module dmem_wbuf
  import dmem_access_unit_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           i_push,
  input  wbuf_entry_t    i_entry,
  input  logic           i_pop,
  output wbuf_entry_t    o_head,
  output logic           o_full,
  output logic           o_empty,
  output logic [PTR_W:0] o_count
);

  wbuf_entry_t      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_entry;
  end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage load/store unit: aligns stores into a posted write buffer, runs one
// outstanding req/addr_ok/data_ok bus transaction, and extends load results.
module dmem_access_unit
  import dmem_access_unit_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int WBUF_DEPTH = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                mem_valid,
  input  logic                mem_wr,
  input  logic [1:0]          mem_size,
  input  logic                mem_unsigned,
  input  logic [31:0]         mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_flush,
  output logic                mem_stall,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_rdata_valid,
  output logic                adel,
  output logic                ades,
  output logic                wbuf_empty,
  output logic                data_req,
  output logic                data_wr,
  output logic [1:0]          data_size,
  output logic [31:0]         data_addr,
  output logic [DATA_W/8-1:0] data_wstrb,
  output logic [DATA_W-1:0]   data_wdata,
  input  logic                data_addr_ok,
  input  logic                data_data_ok,
  input  logic [DATA_W-1:0]   data_rdata,
  output lsu_state_t          o_dbg_state
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = $clog2(WBUF_DEPTH) + 1;

  lsu_state_t        r_state;
  logic              r_req, r_wr;
  logic [1:0]        r_size;
  logic [31:0]       r_addr;
  logic [NB-1:0]     r_wstrb;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic              r_rvalid;
  logic [OFF_W-1:0]  r_ld_off;
  logic [1:0]        r_ld_size;
  logic              r_ld_unsigned, r_ld_kill;

  logic [OFF_W-1:0]  w_off;
  logic              w_misaligned, w_load_req, w_store_req;
  logic              w_fifo_full, w_fifo_empty, w_pop;
  logic [CNT_W-1:0]  w_count;
  logic [7:0]        w_mask8;
  logic [63:0]       w_src64, w_src_msk, w_rd64, w_rd_sh, w_ld_ext;
  logic              w_ld_sign;
  wbuf_entry_t       w_entry, w_head;
  logic              w_unused;

  assign w_off = mem_addr[OFF_W-1:0];

  always_comb begin
    w_misaligned = 1'b0;
    case (mem_size)
      MEM_SIZE_B: w_misaligned = 1'b0;
      MEM_SIZE_H: w_misaligned = mem_addr[0];
      MEM_SIZE_W: w_misaligned = |mem_addr[1:0];
      default:    w_misaligned = (DATA_W == 32) || (|mem_addr[2:0]);
    endcase
  end

  assign adel        = mem_valid & ~mem_wr & w_misaligned;
  assign ades        = mem_valid &  mem_wr & w_misaligned;
  assign w_load_req  = mem_valid & ~mem_wr & ~w_misaligned & ~mem_flush;
  assign w_store_req = mem_valid &  mem_wr & ~w_misaligned & ~mem_flush;

  // Fullness is the registered count, so a same-cycle pop cannot admit a store.
  assign mem_stall = (w_store_req & w_fifo_full) |
                     (w_load_req & (r_state != S_RD_DONE));

  always_comb begin
    w_mask8   = size_mask(mem_size);
    w_src64   = 64'(mem_wdata);
    w_src_msk = '0;
    for (int i = 0; i < 8; i++)
      w_src_msk[i*8 +: 8] = w_mask8[i] ? w_src64[i*8 +: 8] : 8'h00;
    w_entry       = '0;
    w_entry.addr  = mem_addr;
    w_entry.size  = mem_size;
    w_entry.wstrb = w_mask8 << w_off;
    w_entry.wdata = w_src_msk << {w_off, 3'b000};
  end

  assign w_pop = (r_state == S_WR_REQ) & data_addr_ok;

  dmem_wbuf #(
    .DEPTH (WBUF_DEPTH)
  ) u_wbuf (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_store_req),
    .i_entry (w_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_rd64    = 64'(data_rdata);
    w_rd_sh   = w_rd64 >> {r_ld_off, 3'b000};
    w_ld_sign = 1'b0;
    w_ld_ext  = w_rd_sh;
    case (r_ld_size)
      MEM_SIZE_B: begin
        w_ld_sign = ~r_ld_unsigned & w_rd_sh[7];
        w_ld_ext  = {{56{w_ld_sign}}, w_rd_sh[7:0]};
      end
      MEM_SIZE_H: begin
        w_ld_sign = ~r_ld_unsigned & w_rd_sh[15];
        w_ld_ext  = {{48{w_ld_sign}}, w_rd_sh[15:0]};
      end
      MEM_SIZE_W: begin
        w_ld_sign = ~r_ld_unsigned & w_rd_sh[31];
        w_ld_ext  = {{32{w_ld_sign}}, w_rd_sh[31:0]};
      end
      default: w_ld_ext = w_rd_sh;
    endcase
  end

  // Bus registers are only loaded in IDLE, so they hold steady until addr_ok.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_req         <= 1'b0;
      r_wr          <= 1'b0;
      r_size        <= 2'b00;
      r_addr        <= '0;
      r_wstrb       <= '0;
      r_wdata       <= '0;
      r_rdata       <= '0;
      r_rvalid      <= 1'b0;
      r_ld_off      <= '0;
      r_ld_size     <= 2'b00;
      r_ld_unsigned <= 1'b0;
      r_ld_kill     <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_fifo_empty) begin
            r_state <= S_WR_REQ;
            r_req   <= 1'b1;
            r_wr    <= 1'b1;
            r_addr  <= w_head.addr;
            r_size  <= w_head.size;
            r_wstrb <= w_head.wstrb[NB-1:0];
            r_wdata <= w_head.wdata[DATA_W-1:0];
          end else if (w_load_req) begin
            r_state       <= S_RD_REQ;
            r_req         <= 1'b1;
            r_wr          <= 1'b0;
            r_addr        <= mem_addr;
            r_size        <= mem_size;
            r_wstrb       <= '0;
            r_wdata       <= '0;
            r_ld_off      <= w_off;
            r_ld_size     <= mem_size;
            r_ld_unsigned <= mem_unsigned;
            r_ld_kill     <= 1'b0;
          end
        end
        S_WR_REQ: begin
          if (data_addr_ok) begin
            r_req   <= 1'b0;
            r_state <= S_WR_WAIT;
          end
        end
        S_WR_WAIT: begin
          if (data_data_ok) r_state <= S_IDLE;
        end
        S_RD_REQ: begin
          if (mem_flush) r_ld_kill <= 1'b1;
          if (data_addr_ok) begin
            r_req   <= 1'b0;
            r_state <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (data_data_ok) begin
            if (r_ld_kill | mem_flush) begin
              r_state <= S_IDLE;
            end else begin
              r_rdata  <= w_ld_ext[DATA_W-1:0];
              r_rvalid <= 1'b1;
              r_state  <= S_RD_DONE;
            end
          end else if (mem_flush) begin
            r_ld_kill <= 1'b1;
          end
        end
        S_RD_DONE: r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  assign data_req        = r_req;
  assign data_wr         = r_wr;
  assign data_size       = r_size;
  assign data_addr       = r_addr;
  assign data_wstrb      = r_wstrb;
  assign data_wdata      = r_wdata;
  assign mem_rdata       = r_rdata;
  assign mem_rdata_valid = r_rvalid;
  assign wbuf_empty      = w_fifo_empty & (r_state == S_IDLE);
  assign o_dbg_state     = r_state;

  // Upper entry/extension bits are dead on a 32-bit path; count is diagnostic.
  assign w_unused = ^{w_ld_ext, w_head.wstrb, w_head.wdata, w_count};

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: 32-bit instance for lane placement,
// extension, buffering and ordering; 64-bit instance for dword and flush.
module tb_dmem_access_unit;
  import dmem_access_unit_pkg::*;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        mem_valid, mem_wr, mem_unsigned, mem_flush;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_stall, mem_rdata_valid, adel, ades, wbuf_empty;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_wstrb;
  lsu_state_t  dbg_state;

  // 64-bit instance
  logic        q_mem_valid, q_mem_wr, q_mem_unsigned, q_mem_flush;
  logic [1:0]  q_mem_size;
  logic [31:0] q_mem_addr, q_data_addr;
  logic [63:0] q_mem_wdata, q_mem_rdata, q_data_wdata, q_data_rdata;
  logic        q_mem_stall, q_mem_rdata_valid, q_adel, q_ades, q_wbuf_empty;
  logic        q_data_req, q_data_wr, q_data_addr_ok, q_data_data_ok;
  logic [1:0]  q_data_size;
  logic [7:0]  q_data_wstrb;
  lsu_state_t  q_dbg_state;

  dmem_access_unit #(.DATA_W(32), .WBUF_DEPTH(4)) u_dut32 (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_wr(mem_wr),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_flush(mem_flush), .mem_stall(mem_stall),
    .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid), .adel(adel),
    .ades(ades), .wbuf_empty(wbuf_empty), .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr), .data_wstrb(data_wstrb),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata), .o_dbg_state(dbg_state)
  );

  dmem_access_unit #(.DATA_W(64), .WBUF_DEPTH(4)) u_dut64 (
    .clk(clk), .resetn(resetn), .mem_valid(q_mem_valid), .mem_wr(q_mem_wr),
    .mem_size(q_mem_size), .mem_unsigned(q_mem_unsigned), .mem_addr(q_mem_addr),
    .mem_wdata(q_mem_wdata), .mem_flush(q_mem_flush), .mem_stall(q_mem_stall),
    .mem_rdata(q_mem_rdata), .mem_rdata_valid(q_mem_rdata_valid), .adel(q_adel),
    .ades(q_ades), .wbuf_empty(q_wbuf_empty), .data_req(q_data_req),
    .data_wr(q_data_wr), .data_size(q_data_size), .data_addr(q_data_addr),
    .data_wstrb(q_data_wstrb), .data_wdata(q_data_wdata),
    .data_addr_ok(q_data_addr_ok), .data_data_ok(q_data_data_ok),
    .data_rdata(q_data_rdata), .o_dbg_state(q_dbg_state)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] exp_q[$];
  logic [31:0] sram_word;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic wr, input logic [1:0] sz,
                     input logic uns, input logic [31:0] a, input logic [31:0] wd);
    mem_valid = v; mem_wr = wr; mem_size = sz; mem_unsigned = uns;
    mem_addr = a; mem_wdata = wd;
  endtask

  task automatic q_drv(input logic v, input logic wr, input logic [1:0] sz,
                       input logic [31:0] a, input logic [63:0] wd);
    q_mem_valid = v; q_mem_wr = wr; q_mem_size = sz; q_mem_unsigned = 1'b0;
    q_mem_addr = a; q_mem_wdata = wd;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!data_req && n < 16) begin tick(); n++; end
    chk(tag, data_req, 1);
  endtask

  task automatic q_wait_req(input string tag);
    int n = 0;
    while (!q_data_req && n < 16) begin tick(); n++; end
    chk(tag, q_data_req, 1);
  endtask

  task automatic ld_result(input string tag, input logic vld, input logic [63:0] rd);
    logic [63:0] e;
    chk({tag, "_vld"}, vld, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk(tag, rd, e);
    end else begin
      chk({tag, "_noexp"}, 0, 1);
    end
  endtask

  task automatic st(input string tag, input logic [1:0] sz, input logic [31:0] a,
                    input logic [31:0] wd);
    drv(1, 1, sz, 0, a, wd);
    #1 chk({tag, "_stall"}, mem_stall, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr_accept(input string tag, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d);
    wait_req(tag);
    chk({tag, "_wr"}, data_wr, 1);
    chk({tag, "_addr"}, data_addr, a);
    chk({tag, "_strb"}, data_wstrb, s);
    chk({tag, "_wdata"}, data_wdata, d);
    data_addr_ok = 1; tick(); data_addr_ok = 0;
    data_data_ok = 1; tick(); data_data_ok = 0;
  endtask

  task automatic run_load(input string tag, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] rd, input logic [31:0] e);
    exp_q.push_back(64'(e));
    drv(1, 0, sz, uns, a, 0);
    #1 chk({tag, "_stall"}, mem_stall, 1);
    wait_req({tag, "_req"});
    chk({tag, "_rd"}, data_wr, 0);
    chk({tag, "_addr"}, data_addr, a);
    data_addr_ok = 1; tick(); data_addr_ok = 0;
    #1 chk({tag, "_wait_stall"}, mem_stall, 1);
    data_data_ok = 1; data_rdata = rd; tick(); data_data_ok = 0;
    #1 chk({tag, "_done_stall"}, mem_stall, 0);
    ld_result(tag, mem_rdata_valid, 64'(mem_rdata));
    tick();
    drv(0, 0, 0, 0, 0, 0);
    #1 chk({tag, "_vld_once"}, mem_rdata_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drv(0, 0, 0, 0, 0, 0);
    mem_flush = 0; data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
    q_drv(0, 0, 0, 0, 0);
    q_mem_flush = 0; q_data_addr_ok = 0; q_data_data_ok = 0; q_data_rdata = 0;
    sram_word = 32'h0;

    #12;
    chk("rst_req", data_req, 0);
    chk("rst_rdata", mem_rdata, 0);
    chk("rst_rvalid", mem_rdata_valid, 0);
    chk("rst_wbuf_empty", wbuf_empty, 1);
    chk("rst_state", dbg_state, S_IDLE);
    chk("rst_q_wbuf_empty", q_wbuf_empty, 1);
    tick();
    resetn = 1;
    tick();

    // Store lane placement
    st("sb", MEM_SIZE_B, 32'h1003, 32'h0000_00A5);
    wr_accept("sb", 32'h1003, 4'b1000, 32'hA500_0000);
    #1 chk("sb_empty_after", wbuf_empty, 1);
    st("sh", MEM_SIZE_H, 32'h1002, 32'h1234_ABCD);
    wr_accept("sh", 32'h1002, 4'b1100, 32'hABCD_0000);
    st("sw", MEM_SIZE_W, 32'h1004, 32'hCAFE_F00D);
    wr_accept("sw", 32'h1004, 4'b1111, 32'hCAFE_F00D);

    // Load extension
    run_load("lh", MEM_SIZE_H, 0, 32'h2002, 32'h8001_1234, 32'hFFFF_8001);
    run_load("lhu", MEM_SIZE_H, 1, 32'h2002, 32'h8001_1234, 32'h0000_8001);
    run_load("lb", MEM_SIZE_B, 0, 32'h2003, 32'h9A00_0000, 32'hFFFF_FF9A);
    run_load("lbu", MEM_SIZE_B, 1, 32'h2001, 32'h0000_F100, 32'h0000_00F1);

    // Store then load to the same address: write drains before the read
    drv(1, 1, MEM_SIZE_W, 0, 32'h3000, 32'hDEAD_BEEF);
    #1 chk("swlw_st_stall", mem_stall, 0);
    tick();
    drv(1, 0, MEM_SIZE_W, 0, 32'h3000, 0);
    exp_q.push_back(64'h0000_0000_DEAD_BEEF);
    #1 chk("swlw_ld_stall", mem_stall, 1);
    chk("swlw_no_req_yet", data_req, 0);
    tick();
    #1 chk("swlw_wr_first", data_req & data_wr, 1);
    for (int b = 0; b < 4; b++)
      if (data_wstrb[b]) sram_word[b*8 +: 8] = data_wdata[b*8 +: 8];
    data_addr_ok = 1; tick(); data_addr_ok = 0;
    tick();
    #1 chk("swlw_rd_waits_data_ok", data_req, 0);
    data_data_ok = 1; tick(); data_data_ok = 0;
    wait_req("swlw_rd_req");
    chk("swlw_rd", data_wr, 0);
    data_addr_ok = 1; tick(); data_addr_ok = 0;
    data_data_ok = 1; data_rdata = sram_word; tick(); data_data_ok = 0;
    #1 ld_result("swlw_ld", mem_rdata_valid, 64'(mem_rdata));
    tick();
    drv(0, 0, 0, 0, 0, 0);

    // Five back-to-back stores with addr_ok held low
    for (int k = 0; k < 4; k++) begin
      drv(1, 1, MEM_SIZE_W, 0, 32'h100 + 32'(k) * 4, 32'hA0 + 32'(k));
      #1 chk("fill_nostall", mem_stall, 0);
      tick();
    end
    drv(1, 1, MEM_SIZE_W, 0, 32'h110, 32'hA4);
    #1 chk("sw5_stall", mem_stall, 1);
    chk("sw5_req", data_req, 1);
    chk("sw5_head_addr", data_addr, 32'h100);
    tick();
    #1 chk("sw5_hold_stall", mem_stall, 1);
    chk("sw5_hold_addr", data_addr, 32'h100);
    data_addr_ok = 1;
    #1 chk("sw5_no_bypass", mem_stall, 1);
    tick();
    data_addr_ok = 0;
    #1 chk("sw5_freed", mem_stall, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    data_data_ok = 1; tick(); data_data_ok = 0;
    for (int k = 1; k < 5; k++)
      wr_accept("drain", 32'h100 + 32'(k) * 4, 4'hF, 32'hA0 + 32'(k));
    #1 chk("drain_empty", wbuf_empty, 1);

    // Misaligned accesses are dropped
    drv(1, 0, MEM_SIZE_W, 0, 32'h4002, 0);
    #1 chk("lw_mis_adel", adel, 1);
    chk("lw_mis_ades", ades, 0);
    chk("lw_mis_stall", mem_stall, 0);
    tick();
    #1 chk("lw_mis_noreq", data_req, 0);
    drv(1, 1, MEM_SIZE_H, 0, 32'h4001, 32'hFFFF);
    #1 chk("sh_mis_ades", ades, 1);
    chk("sh_mis_adel", adel, 0);
    chk("sh_mis_stall", mem_stall, 0);
    tick();
    drv(1, 1, MEM_SIZE_D, 0, 32'h4000, 32'h1);
    #1 chk("sd32_ades", ades, 1);
    chk("sh_mis_nothing_queued", wbuf_empty, 1);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    #1 chk("mis_noreq", data_req, 0);
    chk("mis_empty", wbuf_empty, 1);

    // 64-bit: dword store, word load with extension, flushed load
    q_drv(1, 1, MEM_SIZE_D, 32'h8, 64'h0123_4567_89AB_CDEF);
    #1 chk("q_sd_stall", q_mem_stall, 0);
    tick();
    q_drv(0, 0, 0, 0, 0);
    q_wait_req("q_sd_req");
    chk("q_sd_wr", q_data_wr, 1);
    chk("q_sd_addr", q_data_addr, 32'h8);
    chk("q_sd_strb", q_data_wstrb, 8'hFF);
    chk("q_sd_wdata", q_data_wdata, 64'h0123_4567_89AB_CDEF);
    q_data_addr_ok = 1; tick(); q_data_addr_ok = 0;
    q_data_data_ok = 1; tick(); q_data_data_ok = 0;

    exp_q.push_back(64'hFFFF_FFFF_8000_0001);
    q_drv(1, 0, MEM_SIZE_W, 32'h14, 0);
    #1 chk("q_lw_stall", q_mem_stall, 1);
    q_wait_req("q_lw_req");
    chk("q_lw_addr", q_data_addr, 32'h14);
    q_data_addr_ok = 1; tick(); q_data_addr_ok = 0;
    q_data_data_ok = 1; q_data_rdata = 64'h8000_0001_0000_0000; tick(); q_data_data_ok = 0;
    #1 ld_result("q_lw", q_mem_rdata_valid, q_mem_rdata);
    tick();
    q_drv(0, 0, 0, 0, 0);

    q_drv(1, 0, MEM_SIZE_D, 32'h10, 0);
    q_wait_req("q_fl_req");
    q_data_addr_ok = 1; tick(); q_data_addr_ok = 0;
    #1 chk("q_fl_in_rd_wait", q_dbg_state, S_RD_WAIT);
    q_mem_flush = 1; tick(); q_mem_flush = 0;
    q_drv(0, 0, 0, 0, 0);
    q_data_data_ok = 1; q_data_rdata = 64'h1111_2222_3333_4444; tick(); q_data_data_ok = 0;
    #1 chk("q_fl_no_valid", q_mem_rdata_valid, 0);
    chk("q_fl_idle", q_dbg_state, S_IDLE);
    chk("q_fl_empty", q_wbuf_empty, 1);
    tick();
    #1 chk("q_fl_no_valid_later", q_mem_rdata_valid, 0);
    chk("q_fl_noreq", q_data_req, 0);

    chk("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Parametrised successor to the MEM-stage store alignment/write-enable logic.
- Aligns store data and generates byte strobes for DATA_W = 32 or 64.
- Posts stores into a WBUF_DEPTH-entry write buffer.
- Executes loads with sign/zero extension and flags misaligned accesses.
- Sits between the MEM stage and the SRAM-like data bus. Drives a single outstanding transaction with the req/addr_ok/data_ok handshake and stalls the pipeline as required.

Parameters:
- DATA_W, 32, data path width; legal values 32 or 64.
- WBUF_DEPTH, 4, store buffer entries; power of two, at least 2.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- mem_valid  in  1  MEM stage access present this cycle
- mem_wr  in  1  1 = store, 0 = load
- mem_size  in  2  00 byte, 01 half, 10 word, 11 dword
- mem_unsigned  in  1  load zero-extend (LBU/LHU)
- mem_addr  in  32  effective address
- mem_wdata  in  DATA_W  store source, right-justified
- mem_flush  in  1  MEM instruction cancelled by exception
- mem_stall  out  1  hold the pipeline
- mem_rdata  out  DATA_W  extended load result
- mem_rdata_valid  out  1  load result valid
- adel  out  1  load address error
- ades  out  1  store address error
- wbuf_empty  out  1  no posted stores and bus idle
- data_req  out  1  bus request
- data_wr  out  1  bus write
- data_size  out  2  bus size code
- data_addr  out  32  bus address
- data_wstrb  out  DATA_W/8  byte strobes
- data_wdata  out  DATA_W  lane-aligned write data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  write done / read data valid
- data_rdata  in  DATA_W  read data

Behaviour:
- Reset, asynchronous on resetn low:
  - FSM returns to IDLE; buffer count and pointers are cleared.
  - data_req=0, mem_rdata=0, mem_rdata_valid=0, wbuf_empty=1.
- Alignment, combinational:
  - OFF = mem_addr[log2(DATA_W/8)-1:0].
  - Half requires addr[0]=0; word requires addr[1:0]=0; dword requires addr[2:0]=0.
  - Size 11 when DATA_W=32 counts as misaligned.
- Exceptions:
  - adel = mem_valid & ~mem_wr & misaligned; ades = mem_valid & mem_wr & misaligned.
  - A flagged access is dropped: no enqueue, no bus traffic, no stall.
- Store lane placement:
  - wdata is the source bytes shifted left by OFF*8, with other bytes zero.
  - wstrb = ((1<<bytes)-1) << OFF.
- Store accept:
  - If mem_valid & mem_wr & ~misaligned & ~mem_flush & count<WBUF_DEPTH, the store is enqueued at the clock edge with no stall.
  - If count==WBUF_DEPTH, mem_stall=1 until a slot frees.
  - A pop in the same cycle does not free a slot for that cycle (no bypass).
- FSM states:
  - IDLE
  - WR_REQ → WR_WAIT (entered on addr_ok) → IDLE (on data_ok)
  - RD_REQ → RD_WAIT (entered on addr_ok) → RD_DONE (on data_ok)
  - RD_DONE → IDLE after one cycle
- FSM priority in IDLE:
  - Buffer non-empty → WR_REQ.
  - Else a valid, aligned, unflushed load → RD_REQ.
  - Loads therefore drain all older stores first.
- Buffer pop and bus hold:
  - The head entry is popped on the WR_REQ addr_ok handshake.
  - data_req and all data_* outputs stay stable from assertion until addr_ok.
- Load stall:
  - mem_stall=1 for a valid, aligned, unflushed load in every state except RD_DONE.
- Load result:
  - On data_ok in RD_WAIT, bytes at OFF are extracted from data_rdata and sign- or zero-extended to DATA_W into mem_rdata.
  - mem_rdata_valid=1 for exactly the RD_DONE cycle; mem_stall=0 in that cycle.
- Flush during a load:
  - In RD_REQ: the request stays held until addr_ok (the protocol forbids withdrawal).
  - In RD_WAIT: the returning data is discarded, mem_rdata_valid stays 0, and the FSM returns to IDLE.
- Flush never cancels buffered stores; they are already committed.
- wbuf_empty = (count==0) & (state==IDLE).

Decomposition:
- Shared package holds:
  - MEM_SIZE_B/H/W/D constants
  - lsu_state_t enum
  - wbuf_entry_t struct (addr, size, wstrb, wdata)
- One sub-module, dmem_wbuf: parametrised FIFO of wbuf_entry_t with push, pop, full, empty and count.

Test Plan:
- DATA_W=32, SB to 0x1003 with wdata=0x000000A5 → bus write with wstrb=1000, wdata=0xA5000000, no stall.
- LH from 0x2002 with rdata=0x8001xxxx, mem_unsigned=0 → mem_rdata=0xFFFF8001; LHU from the same address → 0x00008001. mem_rdata_valid lasts one cycle.
- Five back-to-back SW with data_addr_ok held low and WBUF_DEPTH=4 → mem_stall rises on the fifth store. It clears one cycle after the first addr_ok.
- SW to 0x3000 then LW from 0x3000 → the read is issued only after the write's data_ok, and the load returns the stored value.
- LW to 0x4002 → adel=1, mem_stall=0, no data_req. SH to 0x4001 → ades=1, nothing enqueued.
- DATA_W=64, SD to 0x8 then flush a load asserted during RD_WAIT → wstrb=0xFF. The flushed load produces no mem_rdata_valid and the FSM returns to IDLE.
